conv3x3_stream: RTL and testbench
=================================

# conv3x3_stream

Parametrised streaming 3x3 convolution engine. It is the successor to the fixed 28x28, 3-in/3-out, unit-weight conv layer. Raster pixels enter one per valid cycle, and the block keeps its own two-row line buffers, so no external bank rotation is needed. Weights are signed, runtime-loadable registers, and both channel counts are parameters. Outputs are "valid"-mode convolutions, (IMG_W-2)x(IMG_H-2) per frame, with frame markers for the downstream pooling and write stage.

## Interface
- DATA_W, 8: unsigned pixel width per channel
- CH_IN, 3: input channels, packed in in_data with ch0 in the LSBs
- CH_OUT, 3: output channels (filters)
- W_W, 18: signed weight width
- ACC_W, 32: signed accumulator and output width per channel
- IMG_W, 28: frame width, minimum 3
- IMG_H, 28: frame height, minimum 3
- clk  in  1  single clock; all logic runs on the rising edge
- RESET  in  1  synchronous, active-low reset (0 = reset)
- in_valid  in  1  in_data carries a pixel this cycle
- in_sof  in  1  qualifies in_valid; marks pixel (0,0)
- in_data  in  CH_IN*DATA_W  pixel, all channels
- w_we  in  1  weight write strobe
- w_addr  in  clog2(CH_OUT*CH_IN*9)  weight index = (co*CH_IN+ci)*9 + k, where k = row*3+col and row 0 is the top tap
- w_data  in  W_W  signed weight
- out_valid  out  1  out_data valid
- out_data  out  CH_OUT*ACC_W  signed results, co0 in the LSBs
- out_sof  out  1  with the first output of a frame
- out_eof  out  1  with the last output of a frame
- busy  out  1  a frame is being accepted
- err_sof  out  1  one-cycle pulse: in_sof arrived mid-frame
- w_err  out  1  one-cycle pulse: a weight write was dropped

## Operation
- Idle: pixels with in_valid=1 and in_sof=0 are ignored.
- Frame start: an accepted in_sof pixel sets col=0 and row=0.
  - busy rises the next cycle.
  - Each subsequent valid pixel advances col; at IMG_W-1, col wraps to 0 and row increments.
- Frame end: acceptance of pixel (IMG_H-1, IMG_W-1) ends the frame. busy drops the next cycle, and the state returns to idle.
- Line buffers: two rows of IMG_W words, CH_IN*DATA_W bits each, written at index col on every accepted pixel. They are not reset.
- Window: a 3x3xCH_IN register array shifts left on each accepted pixel. The new right column is {linebuf1[col], linebuf0[col], in_data}, top to bottom.
- Output condition: an output is produced for an accepted pixel at (r,c) only when r>=2 and c>=2. It is the window centred on (r-1,c-1).
- Arithmetic per output channel:
  - sum over ci and k of (zero-extended pixel) x (signed weight).
  - Products are signed DATA_W+W_W+1 bits, sign-extended to ACC_W before summing.
  - Overflow wraps in two's complement; the defaults cannot overflow.
- out_sof: asserted with the output for (2,2).
- out_eof: asserted with the output for (IMG_H-1, IMG_W-1).
- Weights: held in CH_OUT*CH_IN*9 registers, reset to 0.
  - A write is accepted only while busy=0.
  - w_we while busy=1 drops the write and pulses w_err.
  - w_addr out of range: write ignored, no error.
- in_sof while busy (mid-frame restart):
  - err_sof pulses.
  - The frame restarts with this pixel at (0,0).
  - Results already in the pipeline are still delivered.
  - The aborted frame never produces out_eof.
- Simultaneous in_sof and the last pixel of a frame are not possible, since they are the same pixel position. in_sof on the cycle after the last pixel starts a new frame normally.

## Timing
- Pipeline, 3 stages:
  - Stage 1: window and line-buffer update.
  - Stage 2: registered products.
  - Stage 3: registered sums.
- out_valid, out_sof and out_eof assert exactly 3 cycles after the in_valid cycle of the producing pixel.
- Throughput is 1 output per cycle. in_valid may be deasserted arbitrarily; there is no backpressure and no ready signal.
- A weight write is visible to pixels accepted from the next cycle onward.
- Reset: while RESET=0 at a clock edge, the following are all 0 from the next cycle:
  - out_valid, out_sof, out_eof, out_data, busy, err_sof, w_err
  - counters, weights, pipeline valid bits
- Reset mid-frame discards in-flight results.

## Configuration
- CONV_RELU_EN defined: stage 3 registers max(sum, 0) per output channel. Latency is unchanged.
- CONV_RELU_EN undefined: stage 3 registers the raw signed sum.

## Test plan
- Ones test:
  - Setup: IMG_W=IMG_H=5, all weights 1, all pixels 10.
  - Required: 9 outputs per channel, each 270 (10 x 9 taps x 3 channels). out_sof on the 1st output, out_eof on the 9th, each output 3 cycles after its pixel.
- Centre-tap test:
  - Setup: ramp on ch0 = r*5+c, other channels 0, weight co0/ci0/k4 = 1, all other weights 0.
  - Required: co0 outputs 6, 7, 8, 11, …, 18; co1 = co2 = 0.
- Stall test:
  - Setup: same frame as the ones test, with in_valid randomly deasserted 50% of cycles.
  - Required: identical values and order; each out_valid exactly 3 cycles after its pixel.
- Negative-weight test:
  - Setup: all weights -1, pixels 10.
  - Required: -270 on every output without CONV_RELU_EN; 0 with it.
- Restart test:
  - Setup: in_sof at pixel index 7 of a frame.
  - Required: one-cycle err_sof pulse; no out_eof for the aborted frame; the following full frame is correct with out_eof.
- Write-error and reset test:
  - Setup: w_we while busy, then RESET=0 mid-frame.
  - Required: w_err pulses and the weight is unchanged; after reset all outputs are 0, and a reloaded frame gives correct results.

Source files
------------

// File: rtl/conv3x3_stream.sv
// Streaming 3x3 valid-mode convolution: internal two-row line buffers, runtime signed weights, 3-cycle latency, no backpressure.
// Optional CONV_RELU_EN clamps each registered output sum at zero without changing latency.
module conv3x3_stream #(
  parameter int DATA_W = 8,
  parameter int CH_IN  = 3,
  parameter int CH_OUT = 3,
  parameter int W_W    = 18,
  parameter int ACC_W  = 32,
  parameter int IMG_W  = 28,
  parameter int IMG_H  = 28
) (
  input  logic                                  clk,
  input  logic                                  RESET,
  input  logic                                  in_valid,
  input  logic                                  in_sof,
  input  logic [CH_IN*DATA_W-1:0]               in_data,
  input  logic                                  w_we,
  input  logic [$clog2(CH_OUT*CH_IN*9)-1:0]     w_addr,
  input  logic signed [W_W-1:0]                 w_data,
  output logic                                  out_valid,
  output logic [CH_OUT*ACC_W-1:0]               out_data,
  output logic                                  out_sof,
  output logic                                  out_eof,
  output logic                                  busy,
  output logic                                  err_sof,
  output logic                                  w_err
);

  localparam int NW  = CH_OUT * CH_IN * 9;
  localparam int AW  = $clog2(NW);
  localparam int PW  = DATA_W + W_W + 1;
  localparam int PXW = CH_IN * DATA_W;
  localparam int CW  = $clog2(IMG_W);
  localparam int RW  = $clog2(IMG_H);
  localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);

  logic [CW-1:0] col, cur_col;
  logic [RW-1:0] row, cur_row;
  logic          accept, last_px, hit;

  logic [PXW-1:0] lb0 [IMG_W];
  logic [PXW-1:0] lb1 [IMG_W];
  logic [PXW-1:0] win [3][3];

  logic signed [W_W-1:0]   weights [CH_OUT][CH_IN][9];
  logic signed [PW-1:0]    prod_d  [CH_OUT][CH_IN][9];
  logic signed [PW-1:0]    prod_q  [CH_OUT][CH_IN][9];
  logic signed [ACC_W-1:0] sum_d   [CH_OUT];

  logic s1_vld, s1_sof, s1_eof;
  logic s2_vld, s2_sof, s2_eof;

  // An in_sof pixel is always (0,0), whether it opens a frame or restarts one.
  always_comb begin
    cur_col = in_sof ? '0 : col;
    cur_row = in_sof ? '0 : row;
    accept  = in_valid && (busy || in_sof);
    last_px = (cur_row == ROW_LAST) && (cur_col == COL_LAST);
    hit     = (cur_row >= RW'(2)) && (cur_col >= CW'(2));
  end

  always_comb begin
    for (int co = 0; co < CH_OUT; co++) begin
      for (int ci = 0; ci < CH_IN; ci++) begin
        for (int k = 0; k < 9; k++) begin
          prod_d[co][ci][k] = PW'($signed({1'b0, win[k/3][k%3][ci*DATA_W +: DATA_W]}))
                            * PW'(weights[co][ci][k]);
        end
      end
    end
  end

  always_comb begin
    for (int co = 0; co < CH_OUT; co++) begin
      sum_d[co] = '0;
      for (int ci = 0; ci < CH_IN; ci++) begin
        for (int k = 0; k < 9; k++) begin
          sum_d[co] = sum_d[co] + ACC_W'(prod_q[co][ci][k]);
        end
      end
    end
  end

  // Line buffers, window and product registers carry no reset; the valid bits gate them.
  always_ff @(posedge clk) begin
    if (accept) begin
      lb0[cur_col] <= in_data;
      lb1[cur_col] <= lb0[cur_col];
      for (int r = 0; r < 3; r++) begin
        win[r][0] <= win[r][1];
        win[r][1] <= win[r][2];
      end
      win[0][2] <= lb1[cur_col];
      win[1][2] <= lb0[cur_col];
      win[2][2] <= in_data;
    end
    prod_q <= prod_d;
  end

  always_ff @(posedge clk) begin
    if (!RESET) begin
      col       <= '0;
      row       <= '0;
      busy      <= 1'b0;
      err_sof   <= 1'b0;
      w_err     <= 1'b0;
      s1_vld    <= 1'b0;
      s1_sof    <= 1'b0;
      s1_eof    <= 1'b0;
      s2_vld    <= 1'b0;
      s2_sof    <= 1'b0;
      s2_eof    <= 1'b0;
      out_valid <= 1'b0;
      out_sof   <= 1'b0;
      out_eof   <= 1'b0;
      out_data  <= '0;
      for (int co = 0; co < CH_OUT; co++)
        for (int ci = 0; ci < CH_IN; ci++)
          for (int k = 0; k < 9; k++)
            weights[co][ci][k] <= '0;
    end else begin
      err_sof <= accept && in_sof && busy;
      w_err   <= w_we && busy;

      if (accept) begin
        if (last_px) begin
          busy <= 1'b0;
          col  <= '0;
          row  <= '0;
        end else begin
          busy <= 1'b1;
          if (cur_col == COL_LAST) begin
            col <= '0;
            row <= cur_row + 1'b1;
          end else begin
            col <= cur_col + 1'b1;
            row <= cur_row;
          end
        end
      end

      // Out-of-range addresses match no register and are silently ignored.
      if (w_we && !busy) begin
        for (int co = 0; co < CH_OUT; co++)
          for (int ci = 0; ci < CH_IN; ci++)
            for (int k = 0; k < 9; k++)
              if (w_addr == AW'((co * CH_IN + ci) * 9 + k))
                weights[co][ci][k] <= w_data;
      end

      s1_vld <= accept && hit;
      s1_sof <= accept && hit && (cur_row == RW'(2)) && (cur_col == CW'(2));
      s1_eof <= accept && hit && last_px;

      s2_vld <= s1_vld;
      s2_sof <= s1_sof;
      s2_eof <= s1_eof;

      out_valid <= s2_vld;
      out_sof   <= s2_sof;
      out_eof   <= s2_eof;
      for (int co = 0; co < CH_OUT; co++) begin
`ifdef CONV_RELU_EN
        out_data[co*ACC_W +: ACC_W] <= sum_d[co][ACC_W-1] ? '0 : sum_d[co];
`else
        out_data[co*ACC_W +: ACC_W] <= sum_d[co];
`endif
      end
    end
  end

endmodule

// File: tb/tb_conv3x3_stream.sv
// Scoreboard bench for conv3x3_stream on a 5x5 frame: expectations are queued as pixels are driven
// and matched (value, markers, arrival cycle) by a monitor on the falling edge.
module tb_conv3x3_stream;
  localparam int DW = 8, CI = 3, CO = 3, WW = 18, ACW = 32, IW = 5, IH = 5;
  localparam int NW = CO * CI * 9;

  logic clk = 1'b0;
  logic RESET = 1'b0;
  logic in_valid = 1'b0, in_sof = 1'b0;
  logic [CI*DW-1:0] in_data = '0;
  logic w_we = 1'b0;
  logic [6:0] w_addr = '0;
  logic signed [WW-1:0] w_data = '0;
  logic out_valid, out_sof, out_eof, busy, err_sof, w_err;
  logic [CO*ACW-1:0] out_data;

  typedef struct {
    logic [CO*ACW-1:0] dat;
    logic sof;
    logic eof;
    int   cyc;
  } exp_t;

  exp_t q[$];
  int wm [CO][CI][9];
  int cyc = 0, checks = 0, errors = 0, n_err_sof = 0, n_w_err = 0;

  conv3x3_stream #(
    .DATA_W(DW), .CH_IN(CI), .CH_OUT(CO), .W_W(WW), .ACC_W(ACW), .IMG_W(IW), .IMG_H(IH)
  ) dut (
    .clk(clk), .RESET(RESET), .in_valid(in_valid), .in_sof(in_sof), .in_data(in_data),
    .w_we(w_we), .w_addr(w_addr), .w_data(w_data), .out_valid(out_valid), .out_data(out_data),
    .out_sof(out_sof), .out_eof(out_eof), .busy(busy), .err_sof(err_sof), .w_err(w_err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got cyc=%0d required finish", cyc);
    $fatal(1, "watchdog");
  end

  function automatic int pix(int pat, int r, int c, int ch);
    case (pat)
      0:       return 10;
      1:       return (ch == 0) ? r * IW + c : 0;
      default: return (r * 37 + c * 11 + ch * 53 + 5) % 256;
    endcase
  endfunction

  // Reference: window centred on (r-1,c-1), tap k = row*3+col with row 0 on top.
  function automatic logic [CO*ACW-1:0] model(int pat, int r, int c);
    logic [CO*ACW-1:0] v;
    int s;
    v = '0;
    for (int co = 0; co < CO; co++) begin
      s = 0;
      for (int ci = 0; ci < CI; ci++)
        for (int dr = 0; dr < 3; dr++)
          for (int dc = 0; dc < 3; dc++)
            s += pix(pat, r - 2 + dr, c - 2 + dc, ci) * wm[co][ci][dr*3+dc];
`ifdef CONV_RELU_EN
      if (s < 0) s = 0;
`endif
      v[co*ACW +: ACW] = s;
    end
    return v;
  endfunction

  always @(negedge clk) begin
    exp_t e;
    if (err_sof === 1'b1) n_err_sof++;
    if (w_err === 1'b1) n_w_err++;
    if (out_valid === 1'b1) begin
      checks++;
      if (q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_output cyc=%0d got out_valid=1 dat=%h, required no output", cyc, out_data);
      end else begin
        e = q.pop_front();
        if (cyc !== e.cyc || out_data !== e.dat || out_sof !== e.sof || out_eof !== e.eof) begin
          errors++;
          $display("FAIL output cyc=%0d got dat=%h sof=%b eof=%b, required dat=%h sof=%b eof=%b at cyc=%0d",
                   cyc, out_data, out_sof, out_eof, e.dat, e.sof, e.eof, e.cyc);
        end
      end
    end else if (q.size() > 0 && q[0].cyc < cyc) begin
      checks++;
      errors++;
      e = q.pop_front();
      $display("FAIL missing_output cyc=%0d got out_valid=%b, required dat=%h at cyc=%0d", cyc, out_valid, e.dat, e.cyc);
    end
  end

  task automatic idle(int n);
    repeat (n) begin
      @(posedge clk); #1;
      in_valid = 1'b0; in_sof = 1'b0; w_we = 1'b0;
    end
  endtask

  task automatic drive_px(int pat, int r, int c, bit sof);
    exp_t e;
    @(posedge clk); #1;
    in_valid = 1'b1; in_sof = sof; w_we = 1'b0;
    for (int ch = 0; ch < CI; ch++) in_data[ch*DW +: DW] = 8'(pix(pat, r, c, ch));
    if (r >= 2 && c >= 2) begin
      e.dat = model(pat, r, c);
      e.sof = (r == 2 && c == 2);
      e.eof = (r == IH - 1 && c == IW - 1);
      e.cyc = cyc + 3;
      q.push_back(e);
    end
  endtask

  // stop_at: frame abandoned before that pixel index; wr_at: weight write issued alongside that pixel.
  task automatic drive_frame(int pat, int stall, int stop_at, int wr_at);
    for (int idx = 0; idx < IW * IH; idx++) begin
      if (idx == stop_at) return;
      if (idx > 0)
        for (int s = 0; s < 8 && $urandom_range(99) < stall; s++) idle(1);
      drive_px(pat, idx / IW, idx % IW, idx == 0);
      if (idx == wr_at) begin
        w_we = 1'b1; w_addr = 7'd4; w_data = 18'sd77;
      end
    end
  endtask

  task automatic write_w(int addr, int val);
    @(posedge clk); #1;
    in_valid = 1'b0; in_sof = 1'b0;
    w_we = 1'b1; w_addr = 7'(addr); w_data = WW'(val);
    if (addr < NW) wm[addr / (CI * 9)][(addr / 9) % CI][addr % 9] = val;
  endtask

  task automatic load_all(int val);
    for (int i = 0; i < NW; i++) write_w(i, val);
    idle(1);
  endtask

  task automatic drain(string name);
    idle(1);
    for (int i = 0; i < 40 && q.size() != 0; i++) @(negedge clk);
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain_%s got %0d outputs outstanding, required 0", name, q.size());
      q.delete();
    end
  endtask

  task automatic check_zero_state(string name);
    @(negedge clk);
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL %s_out_valid got %b required 0", name, out_valid); end
    checks++; if (out_sof !== 1'b0) begin errors++; $display("FAIL %s_out_sof got %b required 0", name, out_sof); end
    checks++; if (out_eof !== 1'b0) begin errors++; $display("FAIL %s_out_eof got %b required 0", name, out_eof); end
    checks++; if (out_data !== '0) begin errors++; $display("FAIL %s_out_data got %h required 0", name, out_data); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL %s_busy got %b required 0", name, busy); end
    checks++; if (err_sof !== 1'b0) begin errors++; $display("FAIL %s_err_sof got %b required 0", name, err_sof); end
    checks++; if (w_err !== 1'b0) begin errors++; $display("FAIL %s_w_err got %b required 0", name, w_err); end
  endtask

  task automatic clear_model();
    for (int co = 0; co < CO; co++)
      for (int ci = 0; ci < CI; ci++)
        for (int k = 0; k < 9; k++) wm[co][ci][k] = 0;
  endtask

  task automatic test_reset();
    RESET = 1'b0;
    clear_model();
    repeat (2) @(posedge clk);
    check_zero_state("reset");
    @(posedge clk); #1;
    RESET = 1'b1;
    // Zeroed weights: every output of a frame must be 0.
    drive_frame(2, 0, -1, -1);
    drain("reset_zero_weights");
  endtask

  task automatic test_ones();
    load_all(1);
    drive_frame(0, 0, -1, -1);
    @(negedge clk);
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL ones_busy_on_last got %b required 1", busy); end
    idle(1);
    @(negedge clk);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL ones_busy_after got %b required 0", busy); end
    drain("ones");
  endtask

  task automatic test_centre();
    int w0;
    load_all(0);
    write_w(4, 1);
    w0 = n_w_err;
    write_w(100, 5);
    idle(2);
    checks++; if (n_w_err !== w0) begin errors++; $display("FAIL centre_oor_w_err got %0d pulses required 0", n_w_err - w0); end
    drive_frame(1, 0, -1, -1);
    drain("centre");
  endtask

  task automatic test_stall();
    load_all(1);
    drive_frame(0, 50, -1, -1);
    drain("stall");
  endtask

  task automatic test_negative();
    load_all(-1);
    drive_frame(0, 0, -1, -1);
    drain("negative");
  endtask

  task automatic test_random_weights();
    for (int i = 0; i < NW; i++) write_w(i, int'($urandom_range(4000)) - 2000);
    idle(1);
    drive_frame(2, 30, -1, -1);
    drain("random");
  endtask

  task automatic test_back_to_back();
    int e0;
    e0 = n_err_sof;
    drive_frame(2, 0, -1, -1);
    drive_frame(0, 0, -1, -1);
    drain("back_to_back");
    checks++; if (n_err_sof !== e0) begin errors++; $display("FAIL b2b_err_sof got %0d pulses required 0", n_err_sof - e0); end
  endtask

  task automatic test_restart();
    int e0;
    int aborts [2] = '{7, 13};
    foreach (aborts[a]) begin
      e0 = n_err_sof;
      drive_frame(2, 0, aborts[a], -1);
      drive_frame(2, 0, -1, -1);
      drain("restart");
      checks++;
      if (n_err_sof !== e0 + 1) begin
        errors++;
        $display("FAIL restart_%0d_err_sof got %0d cycles high required 1", aborts[a], n_err_sof - e0);
      end
    end
  endtask

  task automatic test_werr_reset();
    int w0;
    load_all(1);
    w0 = n_w_err;
    drive_frame(0, 0, -1, 5);
    drain("werr_frame");
    checks++; if (n_w_err !== w0 + 1) begin errors++; $display("FAIL werr_pulse got %0d cycles high required 1", n_w_err - w0); end
    drive_frame(0, 0, 14, -1);
    @(posedge clk); #1;
    in_valid = 1'b0; in_sof = 1'b0;
    RESET = 1'b0;
    q.delete();
    @(posedge clk);
    check_zero_state("midreset");
    @(posedge clk); #1;
    RESET = 1'b1;
    clear_model();
    idle(6);
    drive_frame(0, 0, -1, -1);
    drain("post_reset_zero");
    load_all(1);
    drive_frame(0, 0, -1, -1);
    drain("post_reset_reload");
  endtask

  initial begin
    test_reset();
    test_ones();
    test_centre();
    test_stall();
    test_negative();
    test_random_weights();
    test_back_to_back();
    test_restart();
    test_werr_reset();
    idle(4);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
